// File: rtl/tdm_demultiplexer_1to8_if.sv
// Link bundle between the 8-slot TDM multiplexer side and the 1-to-8 demultiplexer.
// TDM_DEMUX_FRAME_COUNT_EN adds the FrameCount/ErrCount status counters.
interface tdm_demultiplexer_1to8_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] D;
  logic             Valid;
  logic             Sync;
  logic [WIDTH-1:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
  logic [2:0]       S;
  logic             FrameValid;
  logic             Locked;
  logic             SyncErr;
`ifdef TDM_DEMUX_FRAME_COUNT_EN
  logic [7:0]       FrameCount;
  logic [7:0]       ErrCount;
`endif

  modport master (
    output D, Valid, Sync,
    input  Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, S, FrameValid, Locked, SyncErr
`ifdef TDM_DEMUX_FRAME_COUNT_EN
    , input FrameCount, ErrCount
`endif
  );

  modport slave (
    input  D, Valid, Sync,
    output Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, S, FrameValid, Locked, SyncErr
`ifdef TDM_DEMUX_FRAME_COUNT_EN
    , output FrameCount, ErrCount
`endif
  );
endinterface

// File: rtl/tdm_demultiplexer_1to8.sv
// 1-to-8 TDM demultiplexer: slot shadows, atomic frame publish, hunt/lock alignment.
// TDM_DEMUX_FRAME_COUNT_EN adds a wrapping frame counter and a saturating sync-error counter.
//
// state  | meaning
// HUNT   | not aligned; waiting for a Valid sample with Sync
// LOCKED | aligned; S is the slot the next sample lands in
module tdm_demultiplexer_1to8 #(
  parameter int WIDTH = 1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  tdm_demultiplexer_1to8_if.slave bus
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       s_q, s_d;
  logic [2:0]       wr_idx;
  logic             take, publish, err;
  logic             fv_q, err_q;
  logic [WIDTH-1:0] shadow_q [7];
  logic [WIDTH-1:0] y_q [8];

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.Valid) begin
      case (state_q)
        HUNT:    if (bus.Sync) state_d = LOCKED;
        LOCKED:  if (!bus.Sync && s_q == 3'd0) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Slot 7 is never shadowed: it goes straight to Y on the publish edge.
  always_comb begin
    take    = 1'b0;
    wr_idx  = 3'd0;
    publish = 1'b0;
    err     = 1'b0;
    s_d     = s_q;
    if (bus.Valid) begin
      if (bus.Sync) begin
        take = 1'b1;
        s_d  = 3'd1;
        err  = (state_q == LOCKED) && (s_q != 3'd0);
      end else if (state_q == LOCKED) begin
        if (s_q == 3'd0) begin
          err = 1'b1;
        end else if (s_q == 3'd7) begin
          publish = 1'b1;
          s_d     = 3'd0;
        end else begin
          take   = 1'b1;
          wr_idx = s_q;
          s_d    = s_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s_q   <= 3'd0;
      fv_q  <= 1'b0;
      err_q <= 1'b0;
      for (int i = 0; i < 7; i++) shadow_q[i] <= '0;
      for (int i = 0; i < 8; i++) y_q[i] <= '0;
    end else begin
      s_q   <= s_d;
      fv_q  <= publish;
      err_q <= err;
      for (int i = 0; i < 7; i++)
        if (take && wr_idx == 3'(i)) shadow_q[i] <= bus.D;
      if (publish) begin
        for (int i = 0; i < 7; i++) y_q[i] <= shadow_q[i];
        y_q[7] <= bus.D;
      end
    end
  end

`ifdef TDM_DEMUX_FRAME_COUNT_EN
  logic [7:0] frame_cnt_q, err_cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      frame_cnt_q <= 8'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      if (publish) frame_cnt_q <= frame_cnt_q + 8'd1;
      if (err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.FrameCount = frame_cnt_q;
  assign bus.ErrCount   = err_cnt_q;
`endif

  assign bus.Y0         = y_q[0];
  assign bus.Y1         = y_q[1];
  assign bus.Y2         = y_q[2];
  assign bus.Y3         = y_q[3];
  assign bus.Y4         = y_q[4];
  assign bus.Y5         = y_q[5];
  assign bus.Y6         = y_q[6];
  assign bus.Y7         = y_q[7];
  assign bus.S          = s_q;
  assign bus.FrameValid = fv_q;
  assign bus.Locked     = (state_q == LOCKED);
  assign bus.SyncErr    = err_q;

endmodule

// File: tb/tb_tdm_demultiplexer_1to8.sv
// Bench for tdm_demultiplexer_1to8: directed scenarios plus random traffic against a frame-queue model.
module tb_tdm_demultiplexer_1to8;
  localparam int WIDTH = 4;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  tdm_demultiplexer_1to8_if #(.WIDTH(WIDTH)) bus ();

  tdm_demultiplexer_1to8 #(.WIDTH(WIDTH)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  // Model: a frame is the list of samples collected since the last Sync.
  logic [WIDTH-1:0] m_y [8];
  logic [WIDTH-1:0] partial [$];
  bit               m_locked, m_fv, m_err;
  int               m_fc, m_ec;
  int               n_chk, n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [WIDTH-1:0] dut_y(input int i);
    case (i)
      0: return bus.Y0;
      1: return bus.Y1;
      2: return bus.Y2;
      3: return bus.Y3;
      4: return bus.Y4;
      5: return bus.Y5;
      6: return bus.Y6;
      default: return bus.Y7;
    endcase
  endfunction

  task automatic model_update(input logic [WIDTH-1:0] d, input bit v, input bit s, input bit r);
    m_fv  = 0;
    m_err = 0;
    if (r) begin
      for (int i = 0; i < 8; i++) m_y[i] = '0;
      partial.delete();
      m_locked = 0;
      m_fc = 0;
      m_ec = 0;
    end else if (v) begin
      if (s) begin
        if (m_locked && partial.size() != 0) m_err = 1;
        partial.delete();
        partial.push_back(d);
        m_locked = 1;
      end else if (m_locked) begin
        if (partial.size() == 0) begin
          m_err = 1;
          m_locked = 0;
        end else begin
          partial.push_back(d);
          if (partial.size() == 8) begin
            for (int i = 0; i < 8; i++) m_y[i] = partial[i];
            partial.delete();
            m_fv = 1;
          end
        end
      end
      if (m_fv) m_fc = (m_fc + 1) % 256;
      if (m_err && m_ec < 255) m_ec++;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 8; i++) chk($sformatf("Y%0d", i), 32'(dut_y(i)), 32'(m_y[i]));
    chk("S", 32'(bus.S), 32'(partial.size()));
    chk("FrameValid", 32'(bus.FrameValid), 32'(m_fv));
    chk("Locked", 32'(bus.Locked), 32'(m_locked));
    chk("SyncErr", 32'(bus.SyncErr), 32'(m_err));
`ifdef TDM_DEMUX_FRAME_COUNT_EN
    chk("FrameCount", 32'(bus.FrameCount), 32'(m_fc));
    chk("ErrCount", 32'(bus.ErrCount), 32'(m_ec));
`endif
  endtask

  // Inputs change after the falling edge; outputs are compared on the next falling edge.
  task automatic step(input logic [WIDTH-1:0] d, input bit v, input bit s, input bit r);
    Rst       = r;
    bus.D     = d;
    bus.Valid = v;
    bus.Sync  = s;
    @(posedge Clk);
    model_update(d, v, s, r);
    @(negedge Clk);
    compare_all();
  endtask

  task automatic sample(input int d, input bit s);
    step(WIDTH'(d), 1'b1, s, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int base);
    for (int i = 0; i < 8; i++) sample(base + i, i == 0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    for (int i = 0; i < 8; i++) m_y[i] = '0;
    m_locked = 0;
    m_fc = 0;
    m_ec = 0;
    Rst = 1'b1;
    bus.D = '0;
    bus.Valid = 1'b0;
    bus.Sync = 1'b0;
    @(negedge Clk);
    step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);

    // clean frame 1..8
    frame(1);
    chk("frame1_y0", 32'(bus.Y0), 32'd1);
    chk("frame1_y7", 32'(bus.Y7), 32'd8);
    idle(2);

    // same frame with a 3-cycle Valid gap after slot 3
    for (int i = 0; i < 4; i++) sample(1 + i, i == 0);
    idle(3);
    chk("gap_s_hold", 32'(bus.S), 32'd4);
    for (int i = 4; i < 8; i++) sample(1 + i, 1'b0);

    // pre-sync samples are dropped while hunting
    step('0, 1'b0, 1'b0, 1'b1);
    sample(4'hA, 1'b0);
    sample(4'hB, 1'b0);
    frame(0);
    chk("hunt_frame_y7", 32'(bus.Y7), 32'd7);

    // early sync after 4 slots
    for (int i = 0; i < 4; i++) sample(8 + i, i == 0);
    sample(4'hF, 1'b1);
    for (int i = 1; i < 8; i++) sample(i, 1'b0);
    chk("early_sync_y0", 32'(bus.Y0), 32'hF);

    // missing sync at slot 0
    sample(4'h3, 1'b0);
    idle(1);

    // reset after slot 5 of the second frame
    frame(2);
    for (int i = 0; i < 6; i++) sample(9 + i, i == 0);
    step('0, 1'b0, 1'b0, 1'b1);
    chk("rst_y3", 32'(bus.Y3), 32'd0);

    // 256 back-to-back clean frames wrap the frame counter
    for (int f = 0; f < 256; f++) frame(f);
`ifdef TDM_DEMUX_FRAME_COUNT_EN
    chk("frame_count_wrap", 32'(bus.FrameCount), 32'd0);
`endif

    // random traffic, biased towards well-aligned frames
    for (int n = 0; n < 4000; n++) begin
      bit v, s, r;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) < 7);
      if (partial.size() == 0) s = ($urandom_range(0, 19) < 17);
      else                     s = ($urandom_range(0, 39) == 0);
      step(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), v, s, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/tdm_demultiplexer_1to8.md
Name: tdm_demultiplexer_1to8

Overview:
- Receive end of the 8-slot time-division link driven by the 8-to-1 multiplexer tree.
- Accepts one serialized WIDTH-bit sample per Valid cycle, with Sync marking slot 0.
- Routes each sample to its slot shadow register and publishes all 8 slots atomically once per completed frame.
- Tracks frame alignment (hunt/locked) and flags sync errors.

Parameters:
WIDTH, 1, bit width of each slot sample (D, Y0..Y7)

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  synchronous, active-high reset
D  input  WIDTH  serialized sample from multiplexer side
Valid  input  1  D carries a sample this cycle
Sync  input  1  qualified by Valid; current sample is slot 0
Y0..Y7  output  WIDTH each  registered published slot values of last complete frame
S  output  3  slot index the next accepted sample will be written to
FrameValid  output  1  one-cycle pulse: Y0..Y7 updated this cycle
Locked  output  1  1 = aligned (LOCKED state)
SyncErr  output  1  one-cycle pulse on alignment violation

Behaviour:
- One clock (Clk); reset synchronous, active-high (Rst); Rst has priority over every other input.
- Reset values: Y0..Y7=0, S=0, FrameValid=0, Locked=0, SyncErr=0, shadow registers=0, state HUNT.
- Reset mid-frame discards the partial frame; published Y values also clear to 0.
- All outputs are registered. FrameValid and SyncErr are 0 in any cycle not listed below.
- Cycles with Valid=0 change nothing (Sync ignored). S, shadows and Y hold.
- HUNT (Locked=0):
  - Valid & !Sync: sample dropped, no error.
  - Valid & Sync: shadow0<=D, S<=1, go LOCKED.
- LOCKED (Locked=1), Valid=1:
  - !Sync & S in 1..7: shadow[S]<=D, S<=S+1 (7 wraps to 0).
  - !Sync & S==0 (missing sync): SyncErr<=1, go HUNT, S<=0, sample dropped; Y unchanged.
  - Sync & S==0: normal frame start, shadow0<=D, S<=1.
  - Sync & S!=0 (early sync): SyncErr<=1, partial frame discarded, shadow0<=D, S<=1, stay LOCKED; Y unchanged.
- Frame publish, on the edge accepting slot 7 (Valid & !Sync & S==7):
  - Y0..Y6<=shadow0..6, Y7<=D, FrameValid<=1, S<=0.
  - Y changes only on publish; no partial frame ever reaches Y.
- Latency: slot-7 sample presented in cycle n; Y and FrameValid visible in cycle n+1.
- Back-to-back frames: Sync in the cycle right after the slot-7 sample is legal, giving FrameValid at most once per 8 Valid cycles.

Optional Feature:
- Macro TDM_DEMUX_FRAME_COUNT_EN.
- Defined: adds output FrameCount (8 bits, registered), reset 0, +1 on each FrameValid pulse, wraps 255->0. Adds output ErrCount (8 bits), +1 on each SyncErr pulse, saturates at 255.
- Undefined: neither port exists; all other behaviour identical.

Test Plan:
- WIDTH=4, after reset, 8 consecutive Valid samples 0x1..0x8 with Sync on the first -> Locked=1 after the first; FrameValid pulses once a cycle after 0x8; Y0..Y7=1..8; S=0.
- Same frame with Valid low for 3 cycles between slots 3 and 4 -> identical Y result; FrameValid delayed by exactly 3 cycles; S holds at 4 during the gap.
- Valid samples 0xA,0xB with Sync=0 before any Sync -> dropped, Locked=0, SyncErr=0. Then a full frame 0x0..0x7 -> Y0..Y7=0..7.
- Locked, 4 samples of a frame then Sync with 0xF -> SyncErr pulses, S=1, Y keeps previous frame. Then 7 more samples 0x1..0x7 -> Y0=F, Y1..Y7=1..7.
- Locked at S=0, Valid & !Sync -> SyncErr pulse, Locked=0 next cycle, S=0, Y unchanged.
- Rst asserted after slot 5 of the second frame -> next cycle all Y=0, S=0, Locked=0, FrameValid=0. With TDM_DEMUX_FRAME_COUNT_EN, FrameCount=0; 256 clean frames -> FrameCount=0 again (wrap).
